ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//   Shares the single-cycle RAM port A between two requesters: requester 0 (CPU
//   fetch/load/store path) and requester 1 (external I/O / DMA master).
//   Round-robin arbitration with an optional lock, so a requester can hold the
//   port for read-modify-write sequences. Sits between the CPU datapath and the
//   RAM's a-side (data_a/addr_a/we_a/q_a_out).
//   Grants are issued the same cycle. Read data is valid exactly one cycle after
//   the grant, matching the RAM's registered output.
// PARAMETERS
//   ADDR_W   10  RAM address width
//   DATA_W   16  RAM data width
// PORTS
//   Clk         in   1       system clock, rising edge
//   Rst         in   1       asynchronous reset, active-high
//   req0        in   1       requester 0 access request (level, held until gnt0)
//   we0         in   1       requester 0 write enable (1=write, 0=read)
//   lock0       in   1       requester 0 holds the port after its grant while lock0=1
//   addr0       in   ADDR_W  requester 0 address
//   wdata0      in   DATA_W  requester 0 write data
//   gnt0        out  1       requester 0 access accepted this cycle
//   rvalid0     out  1       rdata valid for requester 0's read granted last cycle
//   req1/we1/lock1/addr1/wdata1, gnt1/rvalid1   same as above, for requester 1
//   rdata       out  DATA_W  read data (ram_q passthrough), qualify with rvalidN
//   ram_addr    out  ADDR_W  to RAM addr_a
//   ram_wdata   out  DATA_W  to RAM data_a
//   ram_we      out  1       to RAM we_a
//   ram_q       in   DATA_W  from RAM q_a_out (registered, 1-cycle latency)
// BEHAVIOUR
//   State: last_gnt (1b, requester granted most recently); owner (2b: NONE,
//     R0, R1 = lock holder); rv0/rv1 (registered read-valid flags).
//   Reset (async, Rst=1): last_gnt=1 (R0 has first priority), owner=NONE,
//     rvalid0=rvalid1=0, gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_wdata=0.
//     Any read in flight is discarded; no rvalid after reset deasserts.
//   Arbitration (combinational, each cycle, Rst=0):
//   - owner=R0: gnt0=req0, gnt1=0. owner=R1: symmetric.
//   - owner=NONE, one request: grant it.
//   - owner=NONE, both requesting: grant the requester != last_gnt.
//   - At most one gnt per cycle. gnt only when the matching req=1.
//   RAM drive: the granted requester's addr/wdata/we go to ram_*.
//     ram_we = gntN & weN. With no grant, ram_we=0 and addr/wdata hold the
//     last driven values (registered copy).
//   Clock edge updates:
//   - On any grant: last_gnt <= winner.
//   - rvalidN <= gntN & ~weN (single-cycle pulse per read grant; back-to-back
//     reads give back-to-back rvalid).
//   - Owner: owner <= RN on gntN & lockN; owner <= NONE when owner=RN & ~lockN
//     (release takes effect next cycle; the release cycle itself still grants
//     only RN).
//   - Lock raised by the non-owner is ignored until it wins a normal grant.
//   Latency: grant 0 cycles after req. Read data 1 cycle after grant. A write is
//     committed at the grant edge. A read of an address written the previous
//     cycle returns the new data.
//   Fairness: with no locks and both requests held, grants alternate
//     R0,R1,R0,... Max wait for a non-locking requester = 1 cycle.
//   Simultaneous events: a grant plus lock release in the same cycle → owner
//     tracks the new grant. Rst beats everything.
// TESTING
//   1 Reset, then req0=1 we0=0 addr0=0x005 (RAM[5]=0xBEEF) → gnt0 same cycle;
//     next cycle rvalid0=1 rdata=0xBEEF; gnt1/rvalid1 stay 0.
//   2 req0=req1=1 held for 6 cycles, no locks → gnt0,gnt1,gnt0,gnt1,gnt0,gnt1;
//     rvalid follows each grant by 1 cycle.
//   3 req1 write addr 0x3FF wdata 0x1234, then req0 read 0x3FF next cycle
//     → ram_we=1 only in the first cycle; rvalid0 with rdata=0x1234.
//   4 req0 with lock0=1 for 4 cycles while req1=1 → gnt0 all 4 cycles, gnt1=0.
//     lock0 drops → gnt1 in the first cycle owner=NONE.
//   5 Rst asserted asynchronously the cycle after a read grant → rvalid0 never
//     pulses. After release, gnt0/gnt1=0 until req; simultaneous req → R0 first.
//   6 No requests for 3 cycles → ram_we=0, gnt0=gnt1=0, rvalid0=rvalid1=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-cycle RAM port A between requester 0
// (CPU path) and requester 1 (I/O / DMA). Same-cycle grants, round-robin
// between contending requesters, and an optional lock so the granted
// requester can keep the port for read-modify-write sequences.
module ram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  // Lock holder: NONE means normal round-robin arbitration.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } owner_t;

  owner_t            ownerR, ownerNext;
  logic              lastGntR, lastGntNext;   // 0 = R0 won most recently, 1 = R1
  logic              rv0R, rv1R;
  logic [ADDR_W-1:0] addrHoldR;
  logic [DATA_W-1:0] wdataHoldR;
  logic              gnt0S, gnt1S;

  // Arbitration: lock holder gets exclusive access, otherwise the requester
  // that did not win last time goes first. Reset suppresses all grants.
  always_comb begin
    gnt0S = 1'b0;
    gnt1S = 1'b0;
    if (Rst) begin
      gnt0S = 1'b0;
      gnt1S = 1'b0;
    end else begin
      case (ownerR)
        OWN_R0: gnt0S = req0;
        OWN_R1: gnt1S = req1;
        OWN_NONE: begin
          if (req0 && req1) begin
            if (lastGntR) begin
              gnt0S = 1'b1;
            end else begin
              gnt1S = 1'b1;
            end
          end else begin
            gnt0S = req0;
            gnt1S = req1;
          end
        end
        default: begin
          gnt0S = 1'b0;
          gnt1S = 1'b0;
        end
      endcase
    end
  end

  // Next lock owner and round-robin pointer. A new locking grant wins over a
  // release; a lock raised by the non-owner only matters once it is granted.
  always_comb begin
    ownerNext   = ownerR;
    lastGntNext = lastGntR;
    if (gnt0S) begin
      lastGntNext = 1'b0;
    end else if (gnt1S) begin
      lastGntNext = 1'b1;
    end else begin
      lastGntNext = lastGntR;
    end
    if (gnt0S && lock0) begin
      ownerNext = OWN_R0;
    end else if (gnt1S && lock1) begin
      ownerNext = OWN_R1;
    end else begin
      case (ownerR)
        OWN_R0:   ownerNext = lock0 ? OWN_R0 : OWN_NONE;
        OWN_R1:   ownerNext = lock1 ? OWN_R1 : OWN_NONE;
        OWN_NONE: ownerNext = OWN_NONE;
        default:  ownerNext = OWN_NONE;
      endcase
    end
  end

  // RAM drive: winner's address/data, else hold the last driven values.
  always_comb begin
    ram_we    = (gnt0S & we0) | (gnt1S & we1);
    ram_addr  = addrHoldR;
    ram_wdata = wdataHoldR;
    if (gnt0S) begin
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1S) begin
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end else begin
      ram_addr  = addrHoldR;
      ram_wdata = wdataHoldR;
    end
  end

  // State register: owner, round-robin pointer, read-valid pipeline, held RAM drive.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ownerR     <= OWN_NONE;
      lastGntR   <= 1'b1;
      rv0R       <= 1'b0;
      rv1R       <= 1'b0;
      addrHoldR  <= {ADDR_W{1'b0}};
      wdataHoldR <= {DATA_W{1'b0}};
    end else begin
      ownerR     <= ownerNext;
      lastGntR   <= lastGntNext;
      rv0R       <= gnt0S & ~we0;
      rv1R       <= gnt1S & ~we1;
      addrHoldR  <= ram_addr;
      wdataHoldR <= ram_wdata;
    end
  end

  assign gnt0    = gnt0S;
  assign gnt1    = gnt1S;
  assign rvalid0 = rv0R;
  assign rvalid1 = rv1R;
  assign rdata   = ram_q;

endmodule
